spi_slave_tx: RTL and testbench
===============================

Name: spi_slave_tx

Overview:
- Synthesizable SPI slave transmitter on the FPGA side of the rpi64 link.
- Holds one word supplied by fabric logic and shifts it out on MISO, LSB first, in SPI mode 0.
- The host reads a frame as: CS_n low, 32 SCLK pulses, CS_n high.
- SCLK and CS_n are asynchronous to CLK; both are oversampled and edge-detected inside the block.

Parameters:
- DATA_W, 32, bits per frame.
- SYNC_STAGES, 2, flip-flop stages in each SCLK/CS_n synchronizer (minimum 2).
- UNDERRUN_WORD, 32'hDEAD_BEEF, word transmitted when a frame starts with no word buffered.

Ports:
- CLK  in  1  system clock; must be at least 8x the SCLK frequency.
- RESET  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from the host; idles low.
- CS_n  in  1  SPI chip select from the host; active low.
- MISO  out  1  serial data to the host.
- data_in  in  DATA_W  word to transmit.
- data_valid  in  1  data_in valid; the word is accepted when data_valid && data_ready.
- data_ready  out  1  high while the holding register is empty.
- tx_done  out  1  one-CLK pulse after the DATA_W-th SCLK rising edge.
- tx_abort  out  1  one-CLK pulse when CS_n rises mid-frame.
- underrun  out  1  one-CLK pulse when a frame starts with the holding register empty.

Behaviour:
- Reset: MISO=0, data_ready=1, tx_done=0, tx_abort=0, underrun=0, holding empty, FSM=IDLE, bit count=0, synchronizer stages preset to idle levels (SCLK=0, CS_n=1).
- Synchronization: each input passes through a SYNC_STAGES flip-flop chain. Edges are detected on the last stage against one further register, giving one-CLK pulses sclk_rise, sclk_fall, cs_fall, cs_rise.
- Holding register (1 entry):
  - Loads on valid && ready.
  - Empties when a frame start consumes it.
  - data_ready is a registered output: low the cycle after an accept, high the cycle after consumption.
- FSM states IDLE, SHIFT, DONE:
  - IDLE:
    - On cs_fall, copy the holding word (or UNDERRUN_WORD if empty) into the shift register; MISO = bit0 on the next CLK.
    - Clear the bit count; go to SHIFT.
    - If the holding register is empty, pulse underrun. A data_valid arriving in the same cycle is stored for the next frame and does not avoid the underrun.
  - SHIFT:
    - sclk_rise: increment the bit count. When the count reaches DATA_W, pulse tx_done and go to DONE.
    - sclk_fall with count < DATA_W: shift right by one; MISO = new bit0.
    - cs_rise: pulse tx_abort; go to IDLE.
    - The host samples MISO on the SCLK rising edge.
  - DONE:
    - MISO = 0.
    - Further SCLK edges are ignored (no shifting, no counting).
    - cs_rise: go to IDLE with no pulse.
- Latency: MISO updates SYNC_STAGES+2 CLK cycles after the pin-level SCLK falling edge or CS_n falling edge. This is within half an SCLK period under the 8x ratio.
- CS_n high (IDLE): MISO=0. No stale shift data is ever presented.
- cs_fall and cs_rise cannot occur in the same CLK (single synchronized signal). SCLK edges seen in IDLE are ignored.
- Simultaneous cs_rise and sclk_rise in SHIFT: cs_rise wins (abort). The bit count is discarded.
- RESET mid-frame: return to reset values immediately. The remainder of the frame reads MISO=0 and no pulses are generated.

Optional Feature:
- Macro SPI_SLAVE_TX_MISO_Z_EN.
- Defined: MISO is 1'bz whenever synchronized CS_n is high or RESET is asserted, so multiple slaves can share the MISO line.
- Undefined: MISO is driven 0 in those conditions.
- All other behaviour is identical in both builds.

Decomposition:
- Package spi_pkg:
  - localparam SPI_WORD_W=32.
  - typedef logic [SPI_WORD_W-1:0] spi_word_t.
  - typedef enum {IDLE, SHIFT, DONE} spi_tx_state_t.
- Sub-module spi_sync_edge:
  - Parameters SYNC_STAGES and RESET_VAL.
  - Outputs: synchronized level, rise pulse, fall pulse.
  - Instantiated once for SCLK and once for CS_n.

Test Plan (CLK 50 MHz; bench SPI master with SCLK period 1 us that samples MISO on the rising edge and shifts in LSB first):
- Push 32'hA5C3_0F81, then run one master read -> received 32'hA5C3_0F81; tx_done pulses once; underrun=0; data_ready returns to 1.
- Read with nothing pushed -> received 32'hDEAD_BEEF; underrun pulses once at the CS_n fall.
- Push 32'h1234_5678, run two back-to-back reads, push 32'h0000_FFFF between them -> reads return 32'h1234_5678 then 32'h0000_FFFF; data_ready=0 between the push and the second CS_n fall.
- Raise CS_n after 10 SCLK pulses of word 32'hFFFF_FFFF -> tx_abort pulses; tx_done stays 0; a following read with new word 32'h0000_0001 returns 32'h0000_0001.
- Assert RESET for 1 CLK at bit 16 -> MISO=0 for the rest of the frame; data_ready=1; the next frame underruns.
- Build with SPI_SLAVE_TX_MISO_Z_EN -> MISO==1'bz while CS_n high; the data check from the first scenario still passes.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared word width, word type and transmitter state encoding
// for the rpi64 SPI link blocks.
`timescale 1ns / 1ps

package spi_pkg;

    localparam int SPI_WORD_W = 32;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer for one asynchronous pin, with
// one-CLK rise/fall pulses taken from the last stage against a delayed copy.
`timescale 1ns / 1ps

module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the pin through the chain; reset presets it to the idle level
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI mode-0 slave transmitter, LSB first, one-word holding
// register. Optional macro SPI_SLAVE_TX_MISO_Z_EN tri-states MISO while
// chip select is inactive or RESET is asserted (otherwise MISO is driven 0).
`timescale 1ns / 1ps

module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int                DATA_W        = SPI_WORD_W,
    parameter int                SYNC_STAGES   = 2,
    parameter logic [DATA_W-1:0] UNDERRUN_WORD = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCLK,
    input  logic              CS_n,
    output logic              MISO,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_done,
    output logic              tx_abort,
    output logic              underrun
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(DATA_W - 1);

    // Only SCLK edges matter; its synchronized level is deliberately unused.
    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;

    spi_tx_state_t     state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] hold_word;
    logic [DATA_W-1:0] load_word;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SYNC_STAGES:0] settle;
    logic              armed;
    logic              frame_start;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk      (CLK),
        .reset    (RESET),
        .async_in (SCLK),
        .level    (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk      (CLK),
        .reset    (RESET),
        .async_in (CS_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Frames may only start once CS_n has truly been seen high after reset,
    // so a reset in the middle of a frame cannot fake a new CS_n fall when
    // the preset synchronizer flushes to the still-low pin.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (settle[SYNC_STAGES] && cs_level) begin
                armed <= 1'b1;
            end
        end
    end

    assign frame_start = (state == IDLE) && cs_fall && armed;
    assign load_word   = data_ready ? UNDERRUN_WORD : hold_word;

    // Holding register, frame FSM, shift register, bit counter and pulses
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            shift_reg  <= '0;
            hold_word  <= '0;
            bit_cnt    <= '0;
            data_ready <= 1'b1;
            tx_done    <= 1'b0;
            tx_abort   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            underrun <= 1'b0;

            if (frame_start && !data_ready) begin
                data_ready <= 1'b1;
            end else if (data_valid && data_ready) begin
                hold_word  <= data_in;
                data_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    shift_reg <= '0;
                    if (frame_start) begin
                        shift_reg <= load_word;
                        underrun  <= data_ready;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        tx_abort  <= 1'b1;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        if (bit_cnt == CNT_PEN) begin
                            tx_done   <= 1'b1;
                            shift_reg <= '0;
                            bit_cnt   <= CNT_LAST;
                            state     <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt < CNT_LAST)) begin
                        shift_reg <= shift_reg >> 1;
                    end
                end
                DONE: begin
                    shift_reg <= '0;
                    if (cs_rise) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_TX_MISO_Z_EN
    assign MISO = (RESET || cs_level) ? 1'bz : shift_reg[0];
`else
    assign MISO = (RESET || cs_level) ? 1'b0 : shift_reg[0];
`endif

endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: SPI master model reading frames from spi_slave_tx and
// checking received words and status pulses against a holding-register model.
`timescale 1ns / 1ps

module tb_spi_slave_tx;

    logic        CLK;
    logic        RESET;
    logic        SCLK;
    logic        CS_n;
    logic        MISO;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        tx_done;
    logic        tx_abort;
    logic        underrun;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCnt     = 0;
    int abortCnt    = 0;
    int underCnt    = 0;

    logic        holdValid;
    logic [31:0] holdWord;
    logic        idleMiso;

    spi_slave_tx dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SCLK       (SCLK),
        .CS_n       (CS_n),
        .MISO       (MISO),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .underrun   (underrun)
    );

    // 50 MHz system clock
    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    // Count every status pulse the DUT produces
    always @(posedge CLK) begin
        if (tx_done)  doneCnt  = doneCnt + 1;
        if (tx_abort) abortCnt = abortCnt + 1;
        if (underrun) underCnt = underCnt + 1;
    end

    function automatic logic [31:0] lowMask(input int n);
        logic [31:0] one;
        one = 32'h1;
        if (n >= 32) return 32'hFFFF_FFFF;
        return (one << n) - 32'h1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushWord(input logic [31:0] w, input string tag);
        @(negedge CLK);
        checkOutput({tag, "_ready_before_push"}, {31'd0, data_ready}, {31'd0, ~holdValid});
        data_in    = w;
        data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        holdValid  = 1'b1;
        holdWord   = w;
        checkOutput({tag, "_ready_after_push"}, {31'd0, data_ready}, 32'd0);
    endtask

    // SPI master: nbits SCLK pulses at 1 us period, LSB first, sampling MISO
    // at each rising edge; optional one-CLK RESET just before bit resetAtBit.
    task automatic applyStimulus(input int nbits, input int resetAtBit,
                                 output logic [31:0] rx);
        rx = '0;
        @(negedge CLK);
        CS_n = 1'b0;
        #500;
        for (int i = 0; i < nbits; i++) begin
            if (i == resetAtBit) begin
                @(negedge CLK);
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
            end
            SCLK  = 1'b1;
            rx[i] = MISO;
            #500;
            SCLK = 1'b0;
            #500;
        end
        CS_n = 1'b1;
        #300;
    endtask

    task automatic runFrame(input int nbits, input int resetAtBit, input string tag);
        logic [31:0] expWord;
        logic [31:0] rx;
        logic        expUnder;
        int          goodBits;
        int          d0, a0, u0;
        expWord  = holdValid ? holdWord : 32'hDEAD_BEEF;
        expUnder = ~holdValid;
        holdValid = 1'b0;
        goodBits = (resetAtBit >= 0 && resetAtBit < nbits) ? resetAtBit : nbits;
        d0 = doneCnt;
        a0 = abortCnt;
        u0 = underCnt;
        applyStimulus(nbits, resetAtBit, rx);
        @(negedge CLK);
        checkOutput({tag, "_rx"}, rx, expWord & lowMask(goodBits));
        checkOutput({tag, "_tx_done"}, 32'(doneCnt - d0),
                    (nbits == 32 && resetAtBit < 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_tx_abort"}, 32'(abortCnt - a0),
                    (nbits < 32 && resetAtBit < 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underCnt - u0), {31'd0, expUnder});
        checkOutput({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
        checkOutput({tag, "_miso_idle"}, {31'd0, MISO}, {31'd0, idleMiso});
    endtask

    initial begin
        logic [31:0] w;
        int          nb;
`ifdef SPI_SLAVE_TX_MISO_Z_EN
        idleMiso = 1'bz;
`else
        idleMiso = 1'b0;
`endif
        holdValid  = 1'b0;
        holdWord   = '0;
        RESET      = 1'b1;
        SCLK       = 1'b0;
        CS_n       = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        $display("[TB] reset state");
        checkOutput("rst_miso", {31'd0, MISO}, {31'd0, idleMiso});
        checkOutput("rst_ready", {31'd0, data_ready}, 32'd1);
        checkOutput("rst_tx_done", {31'd0, tx_done}, 32'd0);
        checkOutput("rst_tx_abort", {31'd0, tx_abort}, 32'd0);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);

        $display("[TB] single word read");
        pushWord(32'hA5C3_0F81, "s1");
        runFrame(32, -1, "s1");

        $display("[TB] underrun read");
        runFrame(32, -1, "s2");

        $display("[TB] back-to-back reads");
        pushWord(32'h1234_5678, "s3a");
        runFrame(32, -1, "s3a");
        pushWord(32'h0000_FFFF, "s3b");
        #2000;
        checkOutput("s3_ready_held_low", {31'd0, data_ready}, 32'd0);
        runFrame(32, -1, "s3b");

        $display("[TB] aborted frame");
        pushWord(32'hFFFF_FFFF, "s4a");
        runFrame(10, -1, "s4a");
        pushWord(32'h0000_0001, "s4b");
        runFrame(32, -1, "s4b");

        $display("[TB] reset mid-frame");
        pushWord(32'h5A5A_C3C3, "s5");
        runFrame(32, 16, "s5");
        runFrame(32, -1, "s5_next");

        $display("[TB] randomized frames");
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                w = $urandom;
                pushWord(w, "rnd");
            end
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            runFrame(nb, -1, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
